add_tree_pipelined: RTL and testbench

//  Fully pipelined, parametrised adder tree. Sums NUM_INPUTS values of INPUT_WIDTH bits.

---
 rtl/add_tree_pkg.sv | 17 +
 rtl/add_tree_level.sv | 39 +++
 rtl/add_tree_pipelined.sv | 88 ++++++++
 tb/tb_add_tree_pipelined.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
package add_tree_pkg;

    function automatic int tree_levels(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int tree_latency(input int n, input int reg_in);
        return reg_in + tree_levels(n);
    endfunction

    // Element count at level k: ceil(n / 2^k)
    function automatic int level_width(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered reduction level: pairs neighbours, passes an odd leftover.
module add_tree_level #(
    parameter int N_IN  = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din [N_IN],
    output logic             valid_out,
    output logic [WIDTH-1:0] dout [(N_IN+1)/2]
);

    localparam int N_OUT = (N_IN + 1) / 2;

    logic [WIDTH-1:0] sum [N_OUT];

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            assign sum[j] = din[2*j] + din[2*j+1];
        end else begin : g_pass
            assign sum[j] = din[2*j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                dout[j] <= '0;
            end
        end else if (en) begin
            valid_out <= valid_in;
            dout      <= sum;
        end
    end

endmodule

// File: rtl/add_tree_pipelined.sv
// Fully pipelined parametrised adder tree with a valid tag and global enable.
module add_tree_pipelined
    import add_tree_pkg::*;
#(
    parameter int NUM_INPUTS   = 8,
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH + $clog2(NUM_INPUTS),
    parameter int SIGNED       = 0,
    parameter int REG_INPUTS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    valid_in,
    input  logic [INPUT_WIDTH-1:0]  inputs [NUM_INPUTS],
    output logic                    valid_out,
    output logic [OUTPUT_WIDTH-1:0] result
);

    localparam int LEVELS = tree_levels(NUM_INPUTS);

    logic [OUTPUT_WIDTH-1:0] ext     [NUM_INPUTS];
    logic [OUTPUT_WIDTH-1:0] tree_in [NUM_INPUTS];
    logic                    tree_v;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ext
        if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_grow
            logic fill;
            assign fill   = (SIGNED != 0) && inputs[i][INPUT_WIDTH-1];
            assign ext[i] = {{(OUTPUT_WIDTH-INPUT_WIDTH){fill}}, inputs[i]};
        end else begin : g_trunc
            assign ext[i] = inputs[i][OUTPUT_WIDTH-1:0];
        end
    end

    if (REG_INPUTS != 0) begin : g_inreg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tree_v <= 1'b0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    tree_in[i] <= '0;
                end
            end else if (en) begin
                tree_v  <= valid_in;
                tree_in <= ext;
            end
        end
    end else begin : g_noreg
        assign tree_v  = valid_in;
        assign tree_in = ext;
    end

    // Each level reads the previous level's outputs by hierarchical name.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = level_width(NUM_INPUTS, k);
        localparam int NO = level_width(NUM_INPUTS, k + 1);

        logic [OUTPUT_WIDTH-1:0] din  [NI];
        logic [OUTPUT_WIDTH-1:0] dout [NO];
        logic                    vin;
        logic                    vout;

        if (k == 0) begin : g_first
            assign din = tree_in;
            assign vin = tree_v;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
        end

        add_tree_level #(
            .N_IN  (NI),
            .WIDTH (OUTPUT_WIDTH)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .valid_in  (vin),
            .din       (din),
            .valid_out (vout),
            .dout      (dout)
        );
    end

    assign result    = g_lvl[LEVELS-1].dout[0];
    assign valid_out = g_lvl[LEVELS-1].vout;

endmodule

// File: tb/tb_add_tree_pipelined.sv
// Directed self-checking bench for add_tree_pipelined in three configurations.
module tb_add_tree_pipelined;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic        va;
    logic [15:0] a [8];
    logic        vo;
    logic [18:0] res;

    logic        v5;
    logic [7:0]  in5 [5];
    logic        vo5;
    logic [10:0] res5;

    logic        vw;
    logic [15:0] inw [8];
    logic        vow;
    logic [15:0] resw;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    add_tree_pipelined dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(va),
        .inputs(a), .valid_out(vo), .result(res)
    );

    add_tree_pipelined #(
        .NUM_INPUTS(5), .INPUT_WIDTH(8), .SIGNED(1)
    ) dut5 (
        .clk(clk), .rst(rst), .en(en), .valid_in(v5),
        .inputs(in5), .valid_out(vo5), .result(res5)
    );

    add_tree_pipelined #(
        .NUM_INPUTS(8), .INPUT_WIDTH(16), .OUTPUT_WIDTH(16)
    ) dutw (
        .clk(clk), .rst(rst), .en(en), .valid_in(vw),
        .inputs(inw), .valid_out(vow), .result(resw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        va  = 1'b0;
        v5  = 1'b0;
        vw  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a[i]   = 16'd0;
            inw[i] = 16'd0;
        end
        for (int i = 0; i < 5; i++) in5[i] = 8'd0;
        #2;
        vectors++;
        if (vo !== 1'b0 || res !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_default: vo=%b res=%h want 0/0", vo, res);
        end
        vectors++;
        if (vo5 !== 1'b0 || res5 !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_signed5: vo=%b res=%h want 0/0", vo5, res5);
        end
        vectors++;
        if (vow !== 1'b0 || resw !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_wrap: vo=%b res=%h want 0/0", vow, resw);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) a[i] = 16'(i + 1);
        va = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) va = 1'b0;
            vectors++;
            if (vo !== (c == 4)) begin
                miscompares++;
                $display("FAIL basic_valid c%0d: got %b want %b", c, vo, c == 4);
            end
        end
        vectors++;
        if (res !== 19'd36) begin
            miscompares++;
            $display("FAIL basic_sum: got %0d want 36", res);
        end
        tick();
    endtask

    task automatic test_max();
        for (int i = 0; i < 8; i++) a[i] = 16'hFFFF;
        va = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) va = 1'b0;
        end
        vectors++;
        if (vo !== 1'b1 || res !== 19'h7FFF8) begin
            miscompares++;
            $display("FAIL max_sum: vo=%b res=%h want 1/7fff8", vo, res);
        end
        tick();
    endtask

    task automatic test_signed5();
        in5[0] = 8'hFF;
        in5[1] = 8'hFE;
        in5[2] = 8'hFD;
        in5[3] = 8'hFC;
        in5[4] = 8'd100;
        v5 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) v5 = 1'b0;
            vectors++;
            if (vo5 !== (c == 4)) begin
                miscompares++;
                $display("FAIL signed5_valid c%0d: got %b want %b", c, vo5, c == 4);
            end
        end
        vectors++;
        if (res5 !== 11'd90) begin
            miscompares++;
            $display("FAIL signed5_sum: got %0d want 90", res5);
        end
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) inw[i] = 16'h4000;
        vw = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) vw = 1'b0;
        end
        vectors++;
        if (vow !== 1'b1 || resw !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_sum: vo=%b res=%h want 1/0000", vow, resw);
        end
        tick();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) a[i] = 16'(i + 1);
        va = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) a[i] = 16'd1;
        tick();
        for (int i = 0; i < 8; i++) a[i] = 16'd100;
        tick();
        va = 1'b0;
        vectors++;
        if (vo !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_early: vo=%b want 0", vo);
        end
        tick();
        vectors++;
        if (vo !== 1'b1 || res !== 19'd36) begin
            miscompares++;
            $display("FAIL stall_a: vo=%b res=%0d want 1/36", vo, res);
        end
        en = 1'b0;
        va = 1'b1;
        for (int i = 0; i < 8; i++) a[i] = 16'd7;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (vo !== 1'b1 || res !== 19'd36) begin
                miscompares++;
                $display("FAIL stall_hold c%0d: vo=%b res=%0d want 1/36", c, vo, res);
            end
        end
        en = 1'b1;
        va = 1'b0;
        tick();
        vectors++;
        if (vo !== 1'b1 || res !== 19'd8) begin
            miscompares++;
            $display("FAIL stall_b: vo=%b res=%0d want 1/8", vo, res);
        end
        tick();
        vectors++;
        if (vo !== 1'b1 || res !== 19'd800) begin
            miscompares++;
            $display("FAIL stall_c: vo=%b res=%0d want 1/800", vo, res);
        end
        tick();
        vectors++;
        if (vo !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_tail: vo=%b want 0", vo);
        end
    endtask

    task automatic test_reset_flight();
        va = 1'b1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) a[i] = 16'(v + 3);
            tick();
        end
        va = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (vo !== 1'b0 || res !== 19'd0) begin
            miscompares++;
            $display("FAIL flight_reset: vo=%b res=%0d want 0/0", vo, res);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (vo !== 1'b0) begin
                miscompares++;
                $display("FAIL flight_drain c%0d: vo=%b want 0", c, vo);
            end
        end
        for (int i = 0; i < 8; i++) a[i] = 16'(i + 1);
        va = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) va = 1'b0;
            vectors++;
            if (vo !== (c == 4)) begin
                miscompares++;
                $display("FAIL flight_new c%0d: got %b want %b", c, vo, c == 4);
            end
        end
        vectors++;
        if (res !== 19'd36) begin
            miscompares++;
            $display("FAIL flight_sum: got %0d want 36", res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_signed5();
        test_wrap();
        test_stall();
        test_reset_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
